// File: rtl/sudoku_grid_reader.sv
// Sudoku grid reader: walks the 81 cells of the solver grid in row-major
// order through the synchronous read port, streams them out on a
// valid/ready interface, and checks every row for a complete 1..9 set.
module sudoku_grid_reader #(
   parameter int GRID_N = 9,
   parameter int VAL_W  = 4,
   parameter int IDX_W  = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   output logic              RdEn,
   output logic [IDX_W-1:0]  RdRow,
   output logic [IDX_W-1:0]  RdCol,
   input  logic [VAL_W-1:0]  RdData,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [IDX_W-1:0]  OutRow,
   output logic [IDX_W-1:0]  OutCol,
   output logic [VAL_W-1:0]  OutValue,
   output logic              Busy,
   output logic              Done,
   output logic [GRID_N-1:0] RowErr,
   output logic              GridOk
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GRID_N - 1);

   logic [1:0]        r_state;
   logic [IDX_W-1:0]  r_rd_row, r_rd_col;
   logic              r_inflight;
   logic [IDX_W-1:0]  r_inf_row, r_inf_col;
   logic [1:0]        r_cnt;
   logic [IDX_W-1:0]  r_head_row, r_head_col, r_tail_row, r_tail_col;
   logic [VAL_W-1:0]  r_head_val, r_tail_val;
   logic [GRID_N-1:0] r_mask;
   logic              r_dup, r_bad;
   logic [GRID_N-1:0] r_row_err;
   logic              r_grid_ok;
   logic              r_done;

   logic              w_pop, w_push, w_rden, w_last_ptr, w_start_ok, w_drain_done;
   logic [2:0]        w_level;
   logic [GRID_N-1:0] w_bit, w_mask_nxt;
   logic              w_hit, w_dup_nxt, w_bad_nxt, w_row_fail;

   // Handshake, issue throttle and FSM transition conditions.
   // The throttle counts this cycle's pop so a full-rate stream keeps issuing.
   always_comb begin
      w_pop        = (r_cnt != 2'd0) && OutReady;
      w_push       = r_inflight;
      w_level      = {1'b0, r_cnt} + {2'b00, r_inflight};
      w_rden       = (r_state == S_ISSUE) && (w_level < (3'd2 + {2'b00, w_pop}));
      w_last_ptr   = (r_rd_row == LAST_IDX) && (r_rd_col == LAST_IDX);
      w_start_ok   = (r_state == S_IDLE) && Start && !r_done;
      w_drain_done = (r_state == S_DRAIN) && !r_inflight && (r_cnt == 2'd1) && w_pop;
   end

   // Row checker: one-hot of the captured digit and the updated row flags.
   always_comb begin
      w_bit = '0;
      for (int i = 0; i < GRID_N; i++) begin
         if (RdData == VAL_W'(i + 1)) w_bit[i] = 1'b1;
      end
      w_hit      = |w_bit;
      w_mask_nxt = r_mask | w_bit;
      w_dup_nxt  = r_dup | (|(r_mask & w_bit));
      w_bad_nxt  = r_bad | !w_hit;
      w_row_fail = w_bad_nxt || w_dup_nxt || (w_mask_nxt != {GRID_N{1'b1}});
   end

   // Control FSM, read pointer, row error bits and completion flags.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state   <= S_IDLE;
         r_rd_row  <= '0;
         r_rd_col  <= '0;
         r_row_err <= '0;
         r_grid_ok <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_state   <= S_ISSUE;
                  r_rd_row  <= '0;
                  r_rd_col  <= '0;
                  r_row_err <= '0;
                  r_grid_ok <= 1'b0;
               end
            end
            S_ISSUE: begin
               if (w_rden) begin
                  if (w_last_ptr) begin
                     r_state <= S_DRAIN;
                  end else if (r_rd_col == LAST_IDX) begin
                     r_rd_col <= '0;
                     r_rd_row <= r_rd_row + IDX_W'(1);
                  end else begin
                     r_rd_col <= r_rd_col + IDX_W'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (w_drain_done) begin
                  r_state   <= S_IDLE;
                  r_done    <= 1'b1;
                  r_grid_ok <= (r_row_err == '0);
               end
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_push && (r_inf_col == LAST_IDX)) r_row_err[r_inf_row] <= w_row_fail;
      end
   end

   // Per-row digit mask and flags, cleared at each row end and on Start.
   always_ff @(posedge Clk) begin
      if (Reset || w_start_ok) begin
         r_mask <= '0;
         r_dup  <= 1'b0;
         r_bad  <= 1'b0;
      end else if (w_push) begin
         if (r_inf_col == LAST_IDX) begin
            r_mask <= '0;
            r_dup  <= 1'b0;
            r_bad  <= 1'b0;
         end else begin
            r_mask <= w_mask_nxt;
            r_dup  <= w_dup_nxt;
            r_bad  <= w_bad_nxt;
         end
      end
   end

   // In-flight read flag; reset discards a pending read.
   always_ff @(posedge Clk) begin
      if (Reset) r_inflight <= 1'b0;
      else       r_inflight <= w_rden;
   end

   // Tag of the in-flight read, used when its data returns.
   always_ff @(posedge Clk) begin
      if (w_rden) begin
         r_inf_row <= RdRow;
         r_inf_col <= RdCol;
      end
   end

   // Two-entry head/tail FIFO; the head holds its contents when emptied.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_cnt      <= 2'd0;
         r_head_row <= '0;
         r_head_col <= '0;
         r_head_val <= '0;
      end else begin
         if (w_push && !w_pop) begin
            if (r_cnt == 2'd0) begin
               r_head_row <= r_inf_row;
               r_head_col <= r_inf_col;
               r_head_val <= RdData;
            end else begin
               r_tail_row <= r_inf_row;
               r_tail_col <= r_inf_col;
               r_tail_val <= RdData;
            end
            r_cnt <= r_cnt + 2'd1;
         end else if (w_pop && !w_push) begin
            if (r_cnt == 2'd2) begin
               r_head_row <= r_tail_row;
               r_head_col <= r_tail_col;
               r_head_val <= r_tail_val;
            end
            r_cnt <= r_cnt - 2'd1;
         end else if (w_push && w_pop) begin
            if (r_cnt == 2'd1) begin
               r_head_row <= r_inf_row;
               r_head_col <= r_inf_col;
               r_head_val <= RdData;
            end else begin
               r_head_row <= r_tail_row;
               r_head_col <= r_tail_col;
               r_head_val <= r_tail_val;
               r_tail_row <= r_inf_row;
               r_tail_col <= r_inf_col;
               r_tail_val <= RdData;
            end
         end
      end
   end

   assign RdEn     = w_rden;
   assign RdRow    = r_rd_row;
   assign RdCol    = r_rd_col;
   assign OutValid = (r_cnt != 2'd0);
   assign OutRow   = r_head_row;
   assign OutCol   = r_head_col;
   assign OutValue = r_head_val;
   assign Busy     = (r_state != S_IDLE);
   assign Done     = r_done;
   assign RowErr   = r_row_err;
   assign GridOk   = r_grid_ok;

endmodule

// File: tb/tb_sudoku_grid_reader.sv
// Testbench for sudoku_grid_reader: models the solver grid read port,
// drives randomized grids and consumer back-pressure, and compares the
// streamed beats, timing and row-check results against a reference model.
module tb_sudoku_grid_reader;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] c;
      logic [3:0] v;
   } beat_t;

   logic       Clk = 1'b0;
   logic       Reset, Start, OutReady;
   logic       RdEn, OutValid, Busy, Done, GridOk;
   logic [3:0] RdRow, RdCol, RdData, OutRow, OutCol, OutValue;
   logic [8:0] RowErr;

   int n_vec = 0;
   int n_err = 0;

   logic [3:0] grid [9][9];

   beat_t beats[$];
   int    rd_first, rd_last, rd_cnt, rd_in50, beat_first, beat_last;
   int    done_cyc, done_cnt, ovf, hold_viol, busy_gap, post_done_act, steady_bad;
   bit    timed_out;

   sudoku_grid_reader #(.GRID_N(9), .VAL_W(4), .IDX_W(4)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start),
      .RdEn(RdEn), .RdRow(RdRow), .RdCol(RdCol), .RdData(RdData),
      .OutValid(OutValid), .OutReady(OutReady),
      .OutRow(OutRow), .OutCol(OutCol), .OutValue(OutValue),
      .Busy(Busy), .Done(Done), .RowErr(RowErr), .GridOk(GridOk)
   );

   always #5 Clk = ~Clk;

   // Solver grid: synchronous read, data valid one cycle after RdEn.
   always @(posedge Clk) begin
      if (RdEn) RdData <= grid[RdRow][RdCol];
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1);
   end

   // Random solved grid: Latin-band pattern relabelled by a random digit permutation.
   task automatic make_solved();
      int perm[9];
      int j, t;
      for (int i = 0; i < 9; i++) perm[i] = i + 1;
      for (int i = 8; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 9; c++)
            grid[r][c] = 4'(perm[(r * 3 + r / 3 + c) % 9]);
   endtask

   // A row is good when each digit 1..9 appears exactly once.
   function automatic logic [8:0] model_row_err();
      logic [8:0] e = '0;
      for (int r = 0; r < 9; r++) begin
         int cnt[16];
         for (int v = 0; v < 16; v++) cnt[v] = 0;
         for (int c = 0; c < 9; c++) cnt[grid[r][c]]++;
         for (int v = 1; v <= 9; v++) if (cnt[v] != 1) e[r] = 1'b1;
      end
      return e;
   endfunction

   // Number of delivered beats that differ from the row-major grid walk.
   function automatic int beat_errs();
      int e = 0;
      beat_t x;
      if (beats.size() != 81) return 81;
      for (int i = 0; i < 81; i++) begin
         x = {4'(i / 9), 4'(i % 9), grid[i / 9][i % 9]};
         if (beats[i] !== x) e++;
      end
      return e;
   endfunction

   function automatic logic ready_for(input int mode, input int cyc);
      case (mode)
         0: return 1'b1;
         1: return (cyc % 2) == 1;
         2: return $urandom_range(0, 3) != 0;
         3: return cyc > 50;
         default: return 1'b1;
      endcase
   endfunction

   // Starts a readout (Start accepted at cycle 0) and records what the DUT does.
   task automatic run_readout(input int mode, input int glitch, input int limit);
      int issued, accepted, cyc, after;
      bit seen_done;
      logic [3:0] pr, pc, pv;
      beats.delete();
      rd_first = -1; rd_last = -1; rd_cnt = 0; rd_in50 = 0;
      beat_first = -1; beat_last = -1; done_cyc = -1; done_cnt = 0;
      ovf = 0; hold_viol = 0; busy_gap = 0; post_done_act = 0; steady_bad = 0;
      timed_out = 0; issued = 0; accepted = 0; cyc = 0; after = 0; seen_done = 0;
      @(negedge Clk);
      Start = 1'b1;
      OutReady = ready_for(mode, 0);
      #1;
      pr = OutRow; pc = OutCol; pv = OutValue;
      while (1) begin
         @(negedge Clk);
         cyc++;
         Start = (cyc == glitch);
         OutReady = ready_for(mode, cyc);
         #1;
         if (RdEn) begin
            issued++; rd_cnt++;
            if (rd_first < 0) rd_first = cyc;
            rd_last = cyc;
            if (cyc <= 50) rd_in50++;
         end
         if (OutValid && OutReady) begin
            beats.push_back({OutRow, OutCol, OutValue});
            accepted++;
            if (beat_first < 0) beat_first = cyc;
            beat_last = cyc;
         end
         if (issued - accepted > 2) ovf++;
         if (!OutValid && ({OutRow, OutCol, OutValue} != {pr, pc, pv})) hold_viol++;
         pr = OutRow; pc = OutCol; pv = OutValue;
         if (mode == 3 && cyc >= 3 && cyc <= 50 &&
             !(OutValid && OutRow == 4'd0 && OutCol == 4'd0 && OutValue == grid[0][0]))
            steady_bad++;
         if (Done) begin
            done_cnt++;
            if (!seen_done) done_cyc = cyc;
            seen_done = 1;
            if (Busy) busy_gap++;
         end else if (!seen_done && !Busy) begin
            busy_gap++;
         end else if (seen_done && (Busy || RdEn)) begin
            post_done_act++;
         end
         if (seen_done) after++;
         if (after > 4) break;
         if (cyc >= limit) begin
            timed_out = 1;
            break;
         end
      end
      Start = 1'b0;
      OutReady = 1'b1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Start = 1'b0; OutReady = 1'b0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      n_vec++; if (RdEn !== 1'b0) begin n_err++; $display("FAIL reset.RdEn got %b want 0", RdEn); end
      n_vec++; if ({RdRow, RdCol} !== 8'h00) begin n_err++; $display("FAIL reset.RdRowCol got %h want 00", {RdRow, RdCol}); end
      n_vec++; if (OutValid !== 1'b0) begin n_err++; $display("FAIL reset.OutValid got %b want 0", OutValid); end
      n_vec++; if ({OutRow, OutCol, OutValue} !== 12'h000) begin n_err++; $display("FAIL reset.OutData got %h want 000", {OutRow, OutCol, OutValue}); end
      n_vec++; if ({Busy, Done, GridOk} !== 3'b000) begin n_err++; $display("FAIL reset.BusyDoneOk got %b want 000", {Busy, Done, GridOk}); end
      n_vec++; if (RowErr !== 9'h000) begin n_err++; $display("FAIL reset.RowErr got %b want 000000000", RowErr); end
      Reset = 1'b0;
   endtask

   task automatic test_full_rate(input string tag, input int glitch);
      make_solved();
      run_readout(0, glitch, 300);
      n_vec++; if (timed_out) begin n_err++; $display("FAIL %s.timeout got timed_out=1 want 0", tag); end
      n_vec++; if (rd_first !== 1 || rd_last !== 81 || rd_cnt !== 81) begin n_err++; $display("FAIL %s.rden got first=%0d last=%0d cnt=%0d want 1 81 81", tag, rd_first, rd_last, rd_cnt); end
      n_vec++; if (beat_first !== 3 || beat_last !== 83) begin n_err++; $display("FAIL %s.beat_timing got first=%0d last=%0d want 3 83", tag, beat_first, beat_last); end
      n_vec++; if (done_cyc !== 84 || done_cnt !== 1) begin n_err++; $display("FAIL %s.done got cycle=%0d count=%0d want 84 1", tag, done_cyc, done_cnt); end
      n_vec++; if (beat_errs() !== 0) begin n_err++; $display("FAIL %s.beats got %0d bad of %0d want 0 bad of 81", tag, beat_errs(), beats.size()); end
      n_vec++; if (RowErr !== model_row_err()) begin n_err++; $display("FAIL %s.RowErr got %b want %b", tag, RowErr, model_row_err()); end
      n_vec++; if (GridOk !== 1'b1) begin n_err++; $display("FAIL %s.GridOk got %b want 1", tag, GridOk); end
      n_vec++; if (hold_viol !== 0 || busy_gap !== 0 || ovf !== 0) begin n_err++; $display("FAIL %s.protocol got hold=%0d busy=%0d ovf=%0d want 0 0 0", tag, hold_viol, busy_gap, ovf); end
   endtask

   task automatic test_ready_toggle();
      make_solved();
      run_readout(1, -1, 400);
      n_vec++; if (timed_out || done_cnt !== 1) begin n_err++; $display("FAIL toggle.done got timeout=%0d count=%0d want 0 1", timed_out, done_cnt); end
      n_vec++; if (beat_errs() !== 0) begin n_err++; $display("FAIL toggle.beats got %0d bad of %0d want 0 bad of 81", beat_errs(), beats.size()); end
      n_vec++; if (ovf !== 0 || rd_cnt !== 81) begin n_err++; $display("FAIL toggle.throttle got ovf=%0d reads=%0d want 0 81", ovf, rd_cnt); end
      n_vec++; if (GridOk !== 1'b1 || RowErr !== 9'h000) begin n_err++; $display("FAIL toggle.check got ok=%b err=%b want 1 000000000", GridOk, RowErr); end
   endtask

   task automatic test_row_errors();
      make_solved();
      for (int c = 0; c < 8; c++) grid[3][c] = 4'(c + 1);
      grid[3][8] = 4'd8;
      grid[7][4] = 4'd0;
      run_readout(2, -1, 600);
      n_vec++; if (timed_out || done_cnt !== 1) begin n_err++; $display("FAIL rowerr.done got timeout=%0d count=%0d want 0 1", timed_out, done_cnt); end
      n_vec++; if (beat_errs() !== 0) begin n_err++; $display("FAIL rowerr.beats got %0d bad want 0", beat_errs()); end
      n_vec++; if (RowErr !== model_row_err()) begin n_err++; $display("FAIL rowerr.RowErr got %b want %b", RowErr, model_row_err()); end
      n_vec++; if (GridOk !== 1'b0) begin n_err++; $display("FAIL rowerr.GridOk got %b want 0", GridOk); end
   endtask

   task automatic test_random_grids();
      for (int k = 0; k < 4; k++) begin
         make_solved();
         for (int n = 0; n < k; n++)
            grid[$urandom_range(0, 8)][$urandom_range(0, 8)] = 4'($urandom_range(0, 15));
         run_readout(2, -1, 600);
         n_vec++; if (timed_out || beat_errs() !== 0 || ovf !== 0) begin n_err++; $display("FAIL random%0d.stream got timeout=%0d bad=%0d ovf=%0d want 0 0 0", k, timed_out, beat_errs(), ovf); end
         n_vec++; if (RowErr !== model_row_err() || GridOk !== (model_row_err() == 9'h000)) begin n_err++; $display("FAIL random%0d.check got err=%b ok=%b want err=%b", k, RowErr, GridOk, model_row_err()); end
      end
   endtask

   task automatic test_reset_midstream();
      int late_done;
      make_solved();
      grid[0][0] = grid[0][1];
      @(negedge Clk);
      Start = 1'b1; OutReady = 1'b1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge Clk);
         Start = 1'b0;
         OutReady = (cyc <= 14);
      end
      #1;
      n_vec++; if (OutValid !== 1'b1 || RowErr[0] !== model_row_err()[0]) begin n_err++; $display("FAIL midreset.before got valid=%b err0=%b want 1 %b", OutValid, RowErr[0], model_row_err()[0]); end
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      n_vec++; if ({OutValid, Busy, Done, RdEn} !== 4'b0000) begin n_err++; $display("FAIL midreset.after got valid/busy/done/rden=%b want 0000", {OutValid, Busy, Done, RdEn}); end
      n_vec++; if (RowErr !== 9'h000) begin n_err++; $display("FAIL midreset.RowErr got %b want 000000000", RowErr); end
      late_done = 0;
      repeat (6) begin
         @(negedge Clk);
         #1;
         if (Done || Busy) late_done++;
      end
      n_vec++; if (late_done !== 0) begin n_err++; $display("FAIL midreset.quiet got %0d active cycles want 0", late_done); end
      run_readout(2, -1, 600);
      n_vec++; if (timed_out || done_cnt !== 1 || beat_errs() !== 0) begin n_err++; $display("FAIL midreset.rerun got timeout=%0d done=%0d bad=%0d want 0 1 0", timed_out, done_cnt, beat_errs()); end
      n_vec++; if (RowErr !== model_row_err() || GridOk !== 1'b0) begin n_err++; $display("FAIL midreset.check got err=%b ok=%b want %b 0", RowErr, GridOk, model_row_err()); end
   endtask

   task automatic test_ready_held_low();
      make_solved();
      run_readout(3, -1, 400);
      n_vec++; if (rd_in50 !== 2) begin n_err++; $display("FAIL holdlow.reads got %0d reads in stall window want 2", rd_in50); end
      n_vec++; if (steady_bad !== 0) begin n_err++; $display("FAIL holdlow.steady got %0d unsteady cycles want 0", steady_bad); end
      n_vec++; if (timed_out || done_cnt !== 1 || beat_errs() !== 0) begin n_err++; $display("FAIL holdlow.resume got timeout=%0d done=%0d bad=%0d want 0 1 0", timed_out, done_cnt, beat_errs()); end
      n_vec++; if (GridOk !== 1'b1 || hold_viol !== 0) begin n_err++; $display("FAIL holdlow.final got ok=%b hold=%0d want 1 0", GridOk, hold_viol); end
   endtask

   task automatic test_back_to_back();
      make_solved();
      run_readout(0, 84, 300);
      n_vec++; if (done_cyc !== 84 || post_done_act !== 0) begin n_err++; $display("FAIL b2b.start_on_done got done=%0d active_after=%0d want 84 0", done_cyc, post_done_act); end
      make_solved();
      run_readout(2, -1, 600);
      n_vec++; if (timed_out || done_cnt !== 1 || beat_errs() !== 0) begin n_err++; $display("FAIL b2b.second got timeout=%0d done=%0d bad=%0d want 0 1 0", timed_out, done_cnt, beat_errs()); end
      n_vec++; if (GridOk !== 1'b1) begin n_err++; $display("FAIL b2b.GridOk got %b want 1", GridOk); end
   endtask

   initial begin
      test_reset();
      test_full_rate("full", -1);
      test_ready_toggle();
      test_row_errors();
      test_full_rate("start_ignored", 40);
      test_reset_midstream();
      test_ready_held_low();
      test_random_grids();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sudoku_grid_reader.md
Name: sudoku_grid_reader

Overview:
- Read-side companion to the Sudoku solver core.
- After the solver reaches its display state, this block walks all 81 grid cells through the solver's synchronous cell read port in row-major order.
- It streams each cell out on a valid/ready interface to the display/UI logic.
- While streaming, it checks each row for a complete 1..9 set and reports per-row errors and an overall grid-OK flag.

Parameters:
- GRID_N, 9, cells per row/column; row/col index range 0..GRID_N-1.
- VAL_W, 4, width of a cell value.
- IDX_W, 4, width of row/col indices.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  single-cycle request to begin a readout; ignored while Busy=1.
- RdEn  out  1  cell read strobe to solver grid.
- RdRow  out  IDX_W  row of the cell being read.
- RdCol  out  IDX_W  column of the cell being read.
- RdData  in  VAL_W  cell value; valid exactly 1 cycle after RdEn=1.
- OutValid  out  1  output beat valid.
- OutReady  in  1  consumer accepts a beat when OutValid&&OutReady.
- OutRow  out  IDX_W  row of current output beat.
- OutCol  out  IDX_W  column of current output beat.
- OutValue  out  VAL_W  value of current output beat.
- Busy  out  1  readout in progress (Start accepted through final beat).
- Done  out  1  1-cycle pulse the cycle after the last beat is accepted.
- RowErr  out  GRID_N  bit r set if row r is not exactly {1..9}.
- GridOk  out  1  1 when the last readout finished with RowErr==0.

Behaviour:
- Reset (synchronous, active-high) state:
  - state=IDLE; RdEn=0; RdRow=RdCol=0; OutValid=0; OutRow/OutCol/OutValue=0.
  - Busy=0; Done=0; RowErr=0; GridOk=0.
  - Output buffer emptied; in-flight read discarded.
  - Reset mid-readout aborts the readout; Done is not pulsed.
- State machine: IDLE -> ISSUE -> DRAIN -> IDLE.
  - IDLE: Start=1 -> ISSUE. On that edge: read pointer (0,0), RowErr cleared, GridOk cleared, row mask cleared, Busy=1 from next cycle.
  - ISSUE: issue a read (RdEn=1 with current RdRow/RdCol) only when buffer occupancy + in-flight reads < 2.
    - Pointer advances col 0..8, then wraps to col 0 of the next row.
    - After the read of (8,8) is issued -> DRAIN; RdEn=0 thereafter.
  - DRAIN: when the buffer is empty, no read is in flight and the last beat is accepted -> IDLE, Done=1 for one cycle, Busy=0, GridOk=(RowErr==0).
- Buffering:
  - 2-entry FIFO of {row, col, value}.
  - RdData is captured into the FIFO on the cycle after RdEn, tagged with the issued row/col.
  - Out* presents the FIFO head; OutValid=!empty.
  - Simultaneous push and pop at occupancy 1 or 2 is legal; occupancy is unchanged.
  - The FIFO never overflows, by the issue rule above.
  - With OutReady held at 1, throughput is 1 beat/cycle.
- Row check, on each RdData capture:
  - Value v in 1..9: if mask[v-1] is already set, mark row duplicate; else set mask[v-1].
  - Value 0 (empty) or >9 marks row bad.
  - On capture of col 8: RowErr[row] <= bad || duplicate || mask!=9'h1FF; mask and flags are then cleared.
  - RowErr bits update as rows complete; they hold until the next accepted Start or Reset.
- Start while Busy=1 is ignored entirely, with no effect on pointer or flags.
- Start in the same cycle as Done returns to IDLE: ignored; a new Start is needed once Busy=0.
- OutRow/OutCol/OutValue are don't-care-stable: they hold their last value while OutValid=0.

Test Plan:
- Valid solved grid, OutReady=1, Start at cycle 0 -> RdEn at cycles 1..81; first OutValid at cycle 3 with (0,0); final beat (8,8) at cycle 83; Done pulse at cycle 84; RowErr=0; GridOk=1; 81 beats in row-major order with values matching the grid.
- Same grid, OutReady toggling 1,0,1,0 -> no beat lost or duplicated; RdEn stalls whenever occupancy+inflight=2; all 81 beats delivered in order; GridOk=1.
- Grid with row 3 = {1,2,3,4,5,6,7,8,8} and row 7 col 4 = 0 -> RowErr=9'b010001000; GridOk=0 after Done.
- Start pulsed at cycle 40 during a readout -> ignored; beat sequence and Done timing are identical to the first scenario.
- Reset asserted at cycle 20 with FIFO holding 2 entries -> next cycle OutValid=0, Busy=0, RowErr=0, no Done; a fresh Start then gives a full correct readout.
- OutReady=0 held for 50 cycles after Start -> exactly 2 reads issued, OutValid=1 steady at (0,0); releasing OutReady resumes the stream with no data loss.
